dot16_operand_loader: RTL and testbench

//  Upstream feeder for the 16-element 11-bit float dot-product stage (sum16).

---
 rtl/dot16_operand_loader.sv | 124 ++++++++++++
 tb/tb_dot16_operand_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot16_operand_loader.sv
// Operand loader for the sum16 dot-product stage: packs (a,b) pairs into
// 16 lanes, zero-pads short vectors and issues them with a minimum spacing.
module dot16_operand_loader #(
    parameter int unsigned ELEM_W    = 11,
    parameter int unsigned N_ELEM    = 16,
    parameter int unsigned ISSUE_GAP = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pushin,
    input  logic [ELEM_W-1:0]        a_in,
    input  logic [ELEM_W-1:0]        b_in,
    input  logic                     last,
    output logic                     stall,
    output logic                     pushout,
    output logic [N_ELEM*ELEM_W-1:0] A,
    output logic [N_ELEM*ELEM_W-1:0] B,
    output logic [4:0]               len,
    output logic [15:0]              nvec
);

    localparam int unsigned IW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LD   = GW'(ISSUE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_ELEM - 1);

    typedef enum logic {FILL, HOLD} state_t;
    typedef logic [N_ELEM-1:0][ELEM_W-1:0] vec_t;

    state_t        state, state_nx;
    vec_t          fa, fb, ha, hb, a_q, b_q, cl_a, cl_b;
    logic [IW-1:0] idx;
    logic [GW-1:0] g;
    logic [4:0]    hlen, cl_len;
    logic          acc, close, issue, hold_ld, src_hold;

    assign A = a_q;
    assign B = b_q;

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        hold_ld  = 1'b0;
        src_hold = 1'b0;
        stall    = (state == HOLD);
        acc      = pushin && (state == FILL);
        close    = acc && (last || (idx == IDX_LAST));
        // Closed vector includes the element accepted at this edge.
        cl_a     = fa;
        cl_b     = fb;
        if (acc) begin
            cl_a[idx] = a_in;
            cl_b[idx] = b_in;
        end
        cl_len = 5'(idx) + 5'd1;
        case (state)
            FILL: begin
                if (close) begin
                    if (g == '0) begin
                        issue = 1'b1;
                    end else begin
                        hold_ld  = 1'b1;
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                if (g == '0) begin
                    issue    = 1'b1;
                    src_hold = 1'b1;
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FILL;
            pushout <= 1'b0;
            fa      <= '0;
            fb      <= '0;
            ha      <= '0;
            hb      <= '0;
            hlen    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            len     <= '0;
            nvec    <= '0;
            idx     <= '0;
            g       <= '0;
        end else begin
            state   <= state_nx;
            pushout <= issue;
            if (acc) begin
                if (close) begin
                    fa  <= '0;
                    fb  <= '0;
                    idx <= '0;
                end else begin
                    fa  <= cl_a;
                    fb  <= cl_b;
                    idx <= idx + IW'(1);
                end
            end
            if (hold_ld) begin
                ha   <= cl_a;
                hb   <= cl_b;
                hlen <= cl_len;
            end
            if (issue) begin
                a_q  <= src_hold ? ha : cl_a;
                b_q  <= src_hold ? hb : cl_b;
                len  <= src_hold ? hlen : cl_len;
                nvec <= nvec + 16'd1;
                g    <= GAP_LD;
            end else if (g != '0) begin
                g <= g - GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dot16_operand_loader.sv
// Scoreboard bench for dot16_operand_loader: a gap-1 instance for throughput,
// padding, reset and wrap cases, and a gap-8 instance for hold/stall timing.
module tb_dot16_operand_loader;

    typedef struct {
        logic [175:0] a;
        logic [175:0] b;
        logic [4:0]   len;
        logic [15:0]  nv;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // gap-1 instance
    logic         p1 = 1'b0, l1 = 1'b0;
    logic [10:0]  a1 = '0, b1 = '0;
    logic         stall1, pushout1;
    logic [175:0] A1, B1;
    logic [4:0]   len1;
    logic [15:0]  nvec1;

    // gap-8 instance
    logic         p8 = 1'b0, l8 = 1'b0;
    logic [10:0]  a8 = '0, b8 = '0;
    logic         stall8, pushout8;
    logic [175:0] A8, B8;
    logic [4:0]   len8;
    logic [15:0]  nvec8;

    dot16_operand_loader #(.ELEM_W(11), .N_ELEM(16), .ISSUE_GAP(1)) dut1 (
        .clk(clk), .reset(reset), .pushin(p1), .a_in(a1), .b_in(b1), .last(l1),
        .stall(stall1), .pushout(pushout1), .A(A1), .B(B1), .len(len1), .nvec(nvec1)
    );

    dot16_operand_loader #(.ELEM_W(11), .N_ELEM(16), .ISSUE_GAP(8)) dut8 (
        .clk(clk), .reset(reset), .pushin(p8), .a_in(a8), .b_in(b8), .last(l8),
        .stall(stall8), .pushout(pushout8), .A(A8), .B(B8), .len(len8), .nvec(nvec8)
    );

    exp_t q1[$];
    exp_t q8[$];
    int   npass = 0;
    int   ntot  = 0;
    logic stall_seen1 = 1'b0;

    function automatic void chk(string nm, logic [175:0] got, logic [175:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endfunction

    // Pushout monitors: pop the scoreboard whenever a vector is presented.
    always @(negedge clk) begin
        if (reset) begin
            if (stall1) stall_seen1 = 1'b1;
            if (pushout1) begin
                if (q1.size() == 0) begin
                    ntot++;
                    $display("FAIL dut1_unexpected_pushout: got pushout=1 expected none at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("dut1_A", A1, e.a);
                    chk("dut1_B", B1, e.b);
                    chk("dut1_len", 176'(len1), 176'(e.len));
                    chk("dut1_nvec", 176'(nvec1), 176'(e.nv));
                    chk("dut1_cycle", 176'(cyc), 176'(e.cyc));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && pushout8) begin
            if (q8.size() == 0) begin
                ntot++;
                $display("FAIL dut8_unexpected_pushout: got pushout=1 expected none at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("dut8_A", A8, e.a);
                chk("dut8_B", B8, e.b);
                chk("dut8_len", 176'(len8), 176'(e.len));
                chk("dut8_nvec", 176'(nvec8), 176'(e.nv));
                chk("dut8_cycle", 176'(cyc), 176'(e.cyc));
            end
        end
    end

    // Expected-vector builder for the gap-1 instance.
    logic [10:0] ma[16];
    logic [10:0] mb[16];
    int          midx = 0;
    logic [15:0] nv1 = '0;
    logic [15:0] nv8 = '0;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        midx = 0;
    endtask

    task automatic send1(input logic [10:0] a, input logic [10:0] b, input logic l);
        p1 = 1'b1; a1 = a; b1 = b; l1 = l;
        ma[midx] = a;
        mb[midx] = b;
        if (l || midx == 15) begin
            exp_t e;
            for (int i = 0; i < 16; i++) begin
                e.a[i*11 +: 11] = ma[i];
                e.b[i*11 +: 11] = mb[i];
            end
            e.len = 5'(midx + 1);
            nv1++;
            e.nv  = nv1;
            e.cyc = cyc + 1;
            q1.push_back(e);
            model_clear();
        end else begin
            midx++;
        end
        @(posedge clk);
        #1;
        p1 = 1'b0; l1 = 1'b0;
    endtask

    function automatic exp_t one_elem(logic [10:0] a, logic [10:0] b, logic [15:0] nv, int c);
        exp_t e;
        e.a = '0;
        e.b = '0;
        e.a[10:0] = a;
        e.b[10:0] = b;
        e.len = 5'd1;
        e.nv  = nv;
        e.cyc = c;
        return e;
    endfunction

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pushout", 176'(pushout1), '0);
        chk("rst_stall", 176'(stall1), '0);
        chk("rst_A", A1, '0);
        chk("rst_len", 176'(len1), '0);
        chk("rst_nvec", 176'(nvec1), '0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Gap 8: single-element vectors in cycles 0 and 1, then pushin held.
        for (int c = 0; c <= 17; c++) begin
            p8 = (c <= 16);
            a8 = 11'(100 + c);
            b8 = 11'(200 + c);
            l8 = 1'b1;
            if (c == 0 || c == 1 || c == 9) begin
                nv8++;
                q8.push_back(one_elem(11'(100 + c), 11'(200 + c), nv8, cyc + ((c == 0) ? 1 : 8)));
            end
            @(negedge clk);
            chk($sformatf("dut8_stall_c%0d", c), 176'(stall8),
                176'(((c >= 2 && c <= 8) || (c >= 10 && c <= 16)) ? 1 : 0));
            @(posedge clk);
            #1;
        end
        p8 = 1'b0; l8 = 1'b0;

        // Full vector a=i, b=16+i, then padded 3-element, then 16+last and 2.
        for (int i = 0; i < 16; i++) send1(11'(i), 11'(16 + i), i == 15);
        for (int i = 0; i < 3; i++)  send1(11'h3C0, 11'h400, i == 2);
        for (int i = 0; i < 16; i++) send1(11'(32 + i), 11'(64 + i), i == 15);
        for (int i = 0; i < 2; i++)  send1(11'(500 + i), 11'(600 + i), i == 1);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle after 5 of 16 elements.
        for (int i = 0; i < 5; i++) send1(11'(700 + i), 11'(800 + i), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_pushout", 176'(pushout1), '0);
        chk("async_stall", 176'(stall1), '0);
        chk("async_A", A1, '0);
        chk("async_B", B1, '0);
        chk("async_len", 176'(len1), '0);
        chk("async_nvec", 176'(nvec1), '0);
        model_clear();
        nv1 = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) send1(11'(900 + i), 11'(1000 + i), i == 15);
        repeat (2) @(posedge clk);
        #1;

        // nvec wrap: reset then 65537 single-element vectors.
        reset = 1'b0;
        #1;
        model_clear();
        nv1 = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 65537; i++) send1(11'(i), 11'(~i), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_nvec", 176'(nvec1), 176'(1));
        chk("wrap_len", 176'(len1), 176'(1));

        repeat (3) @(posedge clk);
        #1;
        chk("q1_drained", 176'(q1.size()), '0);
        chk("q8_drained", 176'(q8.size()), '0);
        chk("dut1_never_stalled", 176'(stall_seen1), '0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
